// File: rtl/mod_counter.sv
// Up/down modulo counter with runtime terminal value, load, clear and wrap/saturate mode.
// Optional sticky overflow flag o_ovf is compiled in with MOD_COUNTER_OVF_STICKY_EN.
module mod_counter #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_up,
   input  logic             i_sat,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic [WIDTH-1:0] i_max_val,
   output logic [WIDTH-1:0] o_count,
   output logic             o_tc,
`ifdef MOD_COUNTER_OVF_STICKY_EN
   output logic             o_ovf,
`endif
   output logic             o_wrap
);

   localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;

   logic             w_over;
   logic             w_at_max;
   logic             w_at_zero;
   logic [WIDTH-1:0] w_load_clamped;
   logic [WIDTH-1:0] w_step_val;
   logic             w_step_wrap;
   logic             w_step_sat;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_wrap_nxt;

   assign w_over    = (r_count > i_max_val);
   assign w_at_max  = (r_count == i_max_val);
   assign w_at_zero = (r_count == '0);

   assign w_load_clamped = (i_load_val > i_max_val) ? i_max_val : i_load_val;

   // Result of one enabled step. An out-of-range count (max_val lowered
   // below it) is pulled back into range regardless of direction.
   always_comb begin
      w_step_val  = r_count;
      w_step_wrap = 1'b0;
      w_step_sat  = 1'b0;
      if (w_over) begin
         if (i_sat) begin
            w_step_val = i_max_val;
            w_step_sat = 1'b1;
         end else begin
            w_step_val  = '0;
            w_step_wrap = 1'b1;
         end
      end else if (i_up) begin
         if (!w_at_max) begin
            w_step_val = r_count + WIDTH'(1);
         end else if (i_sat) begin
            w_step_sat = 1'b1;
         end else begin
            w_step_val  = '0;
            w_step_wrap = 1'b1;
         end
      end else begin
         if (!w_at_zero) begin
            w_step_val = r_count - WIDTH'(1);
         end else if (i_sat) begin
            w_step_sat = 1'b1;
         end else begin
            w_step_val  = i_max_val;
            w_step_wrap = 1'b1;
         end
      end
   end

   // Priority below reset: clr > load > en.
   always_comb begin
      w_count_nxt = r_count;
      w_wrap_nxt  = 1'b0;
      if (i_clr) begin
         w_count_nxt = '0;
      end else if (i_load) begin
         w_count_nxt = w_load_clamped;
      end else if (i_en) begin
         w_count_nxt = w_step_val;
         w_wrap_nxt  = w_step_wrap;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= RST_COUNT;
         r_wrap  <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_wrap  <= w_wrap_nxt;
      end
   end

`ifdef MOD_COUNTER_OVF_STICKY_EN
   logic r_ovf;
   logic w_ovf_set;

   // Sticky: only rst clears it; clr and load leave it alone.
   assign w_ovf_set = w_wrap_nxt || (!i_clr && !i_load && i_en && w_step_sat);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ovf <= 1'b0;
      end else if (w_ovf_set) begin
         r_ovf <= 1'b1;
      end
   end

   assign o_ovf = r_ovf;
`endif

   assign o_count = r_count;
   assign o_wrap  = r_wrap;
   assign o_tc    = i_up ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter (WIDTH=4, RESET_VAL=0) with immediate-assertion checks.
// Also checks o_ovf when built with MOD_COUNTER_OVF_STICKY_EN.
module tb_mod_counter;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         clr;
   logic         en;
   logic         up;
   logic         sat;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] max_val;
   logic [W-1:0] count;
   logic         tc;
   logic         wrap;
`ifdef MOD_COUNTER_OVF_STICKY_EN
   logic         ovf;
`endif

   int vectors;
   int miscompares;

   mod_counter #(.WIDTH(W), .RESET_VAL(0)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_clr      (clr),
      .i_en       (en),
      .i_up       (up),
      .i_sat      (sat),
      .i_load     (load),
      .i_load_val (load_val),
      .i_max_val  (max_val),
      .o_count    (count),
      .o_tc       (tc),
`ifdef MOD_COUNTER_OVF_STICKY_EN
      .o_ovf      (ovf),
`endif
      .o_wrap     (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ovf(input string tag, input logic exp);
`ifdef MOD_COUNTER_OVF_STICKY_EN
      chk(tag, {15'd0, ovf}, {15'd0, exp});
`else
      if (exp === 1'bx) chk(tag, 16'd0, 16'd1);
`endif
   endtask

   logic [W-1:0] exp_up9 [12];

   initial begin
      vectors     = 0;
      miscompares = 0;
      exp_up9     = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};

      rst = 1'b1; clr = 1'b0; en = 1'b0; up = 1'b1; sat = 1'b0;
      load = 1'b0; load_val = '0; max_val = 4'd9;
      step();
      chk("reset_count", 16'(count), 16'd0);
      chk("reset_wrap", 16'(wrap), 16'd0);
      chk_ovf("reset_ovf", 1'b0);

      // Test 1: wrap mode up-count, max 9
      rst = 1'b0; en = 1'b1;
      #1;
      chk("t1_tc_at0", 16'(tc), 16'd0);
      for (int i = 0; i < 12; i++) begin
         step();
         chk("t1_count", 16'(count), 16'(exp_up9[i]));
         chk("t1_wrap", 16'(wrap), (i == 9) ? 16'd1 : 16'd0);
         chk("t1_tc", 16'(tc), (i == 8) ? 16'd1 : 16'd0);
      end
      chk_ovf("t1_ovf_after_wrap", 1'b1);

      // Test 2: down-count wrap from 0 with max 5
      clr = 1'b1;
      step();
      chk("t2_clr", 16'(count), 16'd0);
      clr = 1'b0; up = 1'b0; max_val = 4'd5;
      #1;
      chk("t2_tc_down_at0", 16'(tc), 16'd1);
      step();
      chk("t2_c5", 16'(count), 16'd5);
      chk("t2_wrap5", 16'(wrap), 16'd1);
      step();
      chk("t2_c4", 16'(count), 16'd4);
      chk("t2_wrap4", 16'(wrap), 16'd0);
      step();
      chk("t2_c3", 16'(count), 16'd3);
      chk("t2_tc3", 16'(tc), 16'd0);

      // Test 3: saturating up-count, max 3 (rst first so ovf starts clear)
      rst = 1'b1;
      step();
      chk_ovf("t3_ovf_rst", 1'b0);
      rst = 1'b0; sat = 1'b1; up = 1'b1; max_val = 4'd3;
      step();
      chk("t3_c1", 16'(count), 16'd1);
      step();
      chk("t3_c2", 16'(count), 16'd2);
      step();
      chk("t3_c3", 16'(count), 16'd3);
      chk_ovf("t3_ovf_before_hold", 1'b0);
      chk("t3_tc", 16'(tc), 16'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t3_hold", 16'(count), 16'd3);
         chk("t3_wrap", 16'(wrap), 16'd0);
      end
      chk_ovf("t3_ovf_sticky", 1'b1);

      // Test 4: load clamp, load+clr, in-range load, hold
      en = 1'b0; sat = 1'b0; load = 1'b1; load_val = 4'd12; max_val = 4'd7;
      step();
      chk("t4_load_clamp", 16'(count), 16'd7);
      clr = 1'b1;
      step();
      chk("t4_clr_wins", 16'(count), 16'd0);
      chk_ovf("t4_ovf_kept", 1'b1);
      clr = 1'b0; load_val = 4'd5;
      step();
      chk("t4_load5", 16'(count), 16'd5);
      load = 1'b0;
      step();
      chk("t4_hold", 16'(count), 16'd5);

      // Test 5: max_val lowered below count
      load = 1'b1; load_val = 4'd8; max_val = 4'd15;
      step();
      chk("t5_load8", 16'(count), 16'd8);
      load = 1'b0; max_val = 4'd4; en = 1'b1; up = 1'b1; sat = 1'b0;
      step();
      chk("t5_wrap_count", 16'(count), 16'd0);
      chk("t5_wrap_flag", 16'(wrap), 16'd1);
      step();
      chk("t5_next", 16'(count), 16'd1);
      chk("t5_next_wrap", 16'(wrap), 16'd0);
      en = 1'b0; load = 1'b1; max_val = 4'd15;
      step();
      load = 1'b0; max_val = 4'd4; en = 1'b1; sat = 1'b1;
      step();
      chk("t5_sat_count", 16'(count), 16'd4);
      chk("t5_sat_wrap", 16'(wrap), 16'd0);
      en = 1'b0; load = 1'b1; max_val = 4'd15;
      step();
      load = 1'b0; max_val = 4'd4; en = 1'b1; sat = 1'b0; up = 1'b0;
      step();
      chk("t5_down_over", 16'(count), 16'd0);
      chk("t5_down_over_wrap", 16'(wrap), 16'd1);

      // max_val == 0: stays 0, wraps every step
      max_val = 4'd0; up = 1'b1;
      step();
      chk("mz_c_a", 16'(count), 16'd0);
      chk("mz_w_a", 16'(wrap), 16'd1);
      up = 1'b0;
      step();
      chk("mz_c_b", 16'(count), 16'd0);
      chk("mz_w_b", 16'(wrap), 16'd1);

      // Full range at max_val = 15
      en = 1'b0; load = 1'b1; load_val = 4'd15; max_val = 4'd15; up = 1'b1;
      step();
      chk("fr_load", 16'(count), 16'd15);
      chk("fr_wrap_clear", 16'(wrap), 16'd0);
      load = 1'b0; en = 1'b1;
      step();
      chk("fr_up_wrap", 16'(count), 16'd0);
      chk("fr_up_wflag", 16'(wrap), 16'd1);
      up = 1'b0;
      step();
      chk("fr_down_wrap", 16'(count), 16'd15);
      chk("fr_down_wflag", 16'(wrap), 16'd1);
      en = 1'b0;
      step();
      chk("fr_wrap_drop", 16'(wrap), 16'd0);

      // Test 6: rst mid-count overrides en and load
      load = 1'b1; load_val = 4'd6;
      step();
      chk("t6_load6", 16'(count), 16'd6);
      rst = 1'b1; en = 1'b1; up = 1'b1; load_val = 4'd9;
      step();
      chk("t6_rst_count", 16'(count), 16'd0);
      chk("t6_rst_wrap", 16'(wrap), 16'd0);
      chk_ovf("t6_rst_ovf", 1'b0);
      rst = 1'b0; load = 1'b0;
      step();
      chk("t6_after_rst", 16'(count), 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
